// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures the rising-to-rising period of sig_in in clk cycles.
// Define PERIOD_METER_HIGH_WIDTH_EN to also report the high-phase width on high_time.
module pulse_period_meter #(
    parameter int MAX_COUNT = 100_000_000,
    parameter int CNT_WIDTH = $clog2(MAX_COUNT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sig_in,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 overflow,
    output logic                 busy
`ifdef PERIOD_METER_HIGH_WIDTH_EN
    ,
    output logic [CNT_WIDTH-1:0] high_time
`endif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MEAS = 1'b1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 sync1, sig_s, sig_d, rise;
    logic [0:0]           state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 start, report, hit_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sig_s <= 1'b0;
            sig_d <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sig_s <= sync1;
            sig_d <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_d;

    // A rise outranks the MAX_COUNT check so a period of exactly MAX_COUNT is reported.
    always_comb begin
        start   = (state == IDLE) & enable & rise;
        report  = (state == MEAS) & enable & rise;
        hit_max = (state == MEAS) & enable & ~rise & (cnt == CNT_MAX);
        state_n = start ? MEAS : ((state == MEAS) & (~enable | hit_max)) ? IDLE : state;
        cnt_n   = (start | report) ? CNT_ONE : (state_n == IDLE) ? '0 : cnt + CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_n;
            busy         <= (state_n == MEAS);
            cnt          <= cnt_n;
            period_valid <= report;
            overflow     <= hit_max;
            if (report) period <= cnt;
        end
    end

`ifdef PERIOD_METER_HIGH_WIDTH_EN
    logic                 fall;
    logic [CNT_WIDTH-1:0] hcap;

    assign fall = ~sig_s & sig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcap      <= '0;
            high_time <= '0;
        end else begin
            if ((state == MEAS) & enable & fall) hcap <= cnt;
            if (report) high_time <= hcap;
        end
    end
`endif
endmodule

// File: tb/tb_pulse_period_meter.sv
// tb_pulse_period_meter: directed vector bench for pulse_period_meter with MAX_COUNT=1000.
module tb_pulse_period_meter;
    localparam int MAXC = 1000;
    localparam int W    = $clog2(MAXC + 1);
    localparam int NONE = 1 << 30;
    localparam int N    = 12;

    typedef struct {
        int gap;
        int high;
        int off;
        int nv;
        int per;
        int ovf;
        int hi;
    } vec_t;

    logic         clk = 1'b0, rst = 1'b1, enable = 1'b0, sig_in = 1'b0;
    logic [W-1:0] period;
    logic         period_valid, overflow, busy;
`ifdef PERIOD_METER_HIGH_WIDTH_EN
    logic [W-1:0] high_time;
`endif

    int n_vec = 0, n_err = 0, nv = 0, novf = 0, nboth = 0, t = 0;

    pulse_period_meter #(.MAX_COUNT(MAXC)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .sig_in(sig_in),
        .period(period),
        .period_valid(period_valid),
        .overflow(overflow),
        .busy(busy)
`ifdef PERIOD_METER_HIGH_WIDTH_EN
        ,
        .high_time(high_time)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (period_valid) nv++;
        if (overflow) novf++;
        if (period_valid && overflow) nboth++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    initial begin
        vec_t tv[N];
        int   rise_t[N+1];
        int   nxt, g, nvalid, nbad, first;
        // Each record: a rise, 'high' cycles high, 'gap' cycles until the next rise;
        // expectations are what that gap produces, checked 3 cycles after the next rise.
        tv[0]  = '{50,   20,  NONE, 1, 50,   0, 20};
        tv[1]  = '{50,   20,  NONE, 1, 50,   0, 20};
        tv[2]  = '{37,   5,   NONE, 1, 37,   0, 5};
        tv[3]  = '{2,    1,   NONE, 1, 2,    0, 1};
        tv[4]  = '{2,    1,   NONE, 1, 2,    0, 1};
        tv[5]  = '{3,    2,   NONE, 1, 3,    0, 2};
        tv[6]  = '{1000, 10,  NONE, 1, 1000, 0, 10};
        tv[7]  = '{1001, 10,  NONE, 0, 1000, 1, 10};
        tv[8]  = '{999,  500, NONE, 1, 999,  0, 500};
        tv[9]  = '{50,   20,  20,   0, 999,  0, 500};
        tv[10] = '{50,   20,  NONE, 1, 50,   0, 20};
        tv[11] = '{1500, 1,   NONE, 0, 50,   1, 20};

        repeat (3) step();
        sample();
        chk("reset period", int'(period), 0);
        chk("reset period_valid", int'(period_valid), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset busy", int'(busy), 0);
`ifdef PERIOD_METER_HIGH_WIDTH_EN
        chk("reset high_time", int'(high_time), 0);
`endif
        step();
        rst = 1'b0;
        enable = 1'b1;
        nv = 0; novf = 0; nboth = 0;
        nxt = 1;
        for (int k = 0; k <= N; k++) begin
            rise_t[k] = t;
            g = (k < N) ? tv[k].gap : 4;
            for (int c = 0; c < g; c++) begin
                sig_in = (k < N) ? (c < tv[k].high) : 1'b1;
                enable = (k < N) ? (c < tv[k].off) : 1'b1;
                sample();
                if (nxt <= k && t == rise_t[nxt] + 3) begin
                    chk($sformatf("v%0d valid count", nxt - 1), nv, tv[nxt-1].nv);
                    chk($sformatf("v%0d overflow count", nxt - 1), novf, tv[nxt-1].ovf);
                    chk($sformatf("v%0d valid+overflow", nxt - 1), nboth, 0);
                    chk($sformatf("v%0d period", nxt - 1), int'(period), tv[nxt-1].per);
                    chk($sformatf("v%0d busy", nxt - 1), int'(busy), 1);
`ifdef PERIOD_METER_HIGH_WIDTH_EN
                    chk($sformatf("v%0d high_time", nxt - 1), int'(high_time), tv[nxt-1].hi);
`endif
                    nv = 0; novf = 0; nboth = 0;
                    nxt++;
                end
                if (k < N && c == tv[k].off + 1)
                    chk($sformatf("v%0d busy after disable", k), int'(busy), 0);
                step();
            end
        end
        chk("all vector checks reached", nxt, N + 1);

        // Asynchronous reset in the middle of a measurement.
        sig_in = 1'b0;
        repeat (500) begin sample(); step(); end
        sample();
        chk("busy before mid reset", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("async reset period", int'(period), 0);
        chk("async reset busy", int'(busy), 0);
        chk("async reset strobes", int'(period_valid) + int'(overflow), 0);
        repeat (3) step();
        rst = 1'b0;
        nvalid = 0; nbad = 0;
        for (int c = 0; c < 30; c++) begin
            sig_in = (c % 2 == 0);
            sample();
            if (c >= 10 && period_valid) begin
                nvalid++;
                if (period != W'(2)) nbad++;
            end
            step();
        end
        chk("period-2 valid count", nvalid, 10);
        chk("period-2 wrong periods", nbad, 0);

        // Input held high across reset release: one start edge, then overflow.
        rst = 1'b1;
        sig_in = 1'b1;
        enable = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        novf = 0; first = -1;
        for (int c = 0; c <= 1100; c++) begin
            sample();
            if (c == 4) chk("busy after high start", int'(busy), 1);
            if (overflow && first < 0) first = c;
            step();
        end
        chk("held-high overflow count", novf, 1);
        chk("held-high overflow cycle", first, 1003);
        chk("held-high busy end", int'(busy), 0);
        chk("held-high period", int'(period), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
